noc_switch_allocator: RTL and testbench

//  Packet-level switch allocator for the 5-port router (R, L, U, D, EJ). Each input presents a head-flit

---
 rtl/noc_pkg.sv | 20 ++
 rtl/rr_arbiter.sv | 36 +++
 rtl/noc_switch_allocator.sv | 179 +++++++++++++++++
 tb/tb_noc_switch_allocator.sv | 386 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared router constants: port count, port index width, port encodings and credit depth.
package noc_pkg;

  localparam int NPORTS  = 5;
  localparam int PORT_W  = 3;
  localparam int CREDITS = 4;
  localparam int CRED_W  = 3;

  localparam logic [PORT_W-1:0] PORT_R  = 3'd0;
  localparam logic [PORT_W-1:0] PORT_L  = 3'd1;
  localparam logic [PORT_W-1:0] PORT_U  = 3'd2;
  localparam logic [PORT_W-1:0] PORT_D  = 3'd3;
  localparam logic [PORT_W-1:0] PORT_EJ = 3'd4;

  typedef enum logic {
    OUT_IDLE   = 1'b0,
    OUT_LOCKED = 1'b1
  } out_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches upward from ptr_i (wrapping) and returns the first requester
// as one-hot grant plus index, and the pointer value that follows it.
module rr_arbiter
  import noc_pkg::*;
(
  input  logic [NPORTS-1:0] req_i,
  input  logic [PORT_W-1:0] ptr_i,
  output logic              valid_o,
  output logic [NPORTS-1:0] gnt_o,
  output logic [PORT_W-1:0] gnt_idx_o,
  output logic [PORT_W-1:0] ptr_nxt_o
);

  always_comb begin
    logic [PORT_W:0]   pos;
    logic [PORT_W-1:0] idx;
    pos       = '0;
    idx       = '0;
    valid_o   = 1'b0;
    gnt_o     = '0;
    gnt_idx_o = '0;
    ptr_nxt_o = ptr_i;
    for (int off = 0; off < NPORTS; off++) begin
      pos = {1'b0, ptr_i} + (PORT_W+1)'(off);
      if (pos >= (PORT_W+1)'(NPORTS)) pos = pos - (PORT_W+1)'(NPORTS);
      idx = pos[PORT_W-1:0];
      if (!valid_o && req_i[idx]) begin
        valid_o   = 1'b1;
        gnt_o[idx] = 1'b1;
        gnt_idx_o = idx;
        ptr_nxt_o = (idx == PORT_W'(NPORTS-1)) ? '0 : idx + 1'b1;
      end
    end
  end

endmodule

// File: rtl/noc_switch_allocator.sv
// Packet-level switch allocator: one lock FSM and round-robin arbiter per output port.
// Define SWA_CREDIT_EN to add per-output downstream credit counters gating flit_ok.
//
// state      | meaning
// OUT_IDLE   | output free; arbitrates among eligible inputs this cycle
// OUT_LOCKED | output owned by input sel_q until that input's tail flit transfers
module noc_switch_allocator
  import noc_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NPORTS-1:0]        req_valid,
  input  logic [NPORTS*PORT_W-1:0] req_dst,
  input  logic [NPORTS-1:0]        in_xfer,
  input  logic [NPORTS-1:0]        in_tail,
  input  logic [NPORTS-1:0]        credit_ret,
  output logic [NPORTS-1:0]        gnt,
  output logic [NPORTS-1:0]        flit_ok,
  output logic [NPORTS*PORT_W-1:0] xbar_sel,
  output logic [NPORTS-1:0]        out_busy,
  output logic                     err
);

  out_state_e        state_q [NPORTS];
  out_state_e        state_d [NPORTS];
  logic [PORT_W-1:0] sel_q   [NPORTS];
  logic [PORT_W-1:0] sel_d   [NPORTS];
  logic [PORT_W-1:0] ptr_q   [NPORTS];
  logic [PORT_W-1:0] ptr_d   [NPORTS];
  logic [NPORTS-1:0] gnt_q, gnt_d;
  logic              err_q, err_d;

  logic [NPORTS-1:0] arb_req [NPORTS];
  logic [NPORTS-1:0] arb_gnt [NPORTS];
  logic [PORT_W-1:0] arb_idx [NPORTS];
  logic [PORT_W-1:0] arb_ptr [NPORTS];
  logic [NPORTS-1:0] arb_valid;

  logic [NPORTS-1:0] owns, credit_ok, accept, bad_dst;
  logic [NPORTS-1:0] out_acc, out_rel, has_cred, cred_ovf, granted;

  // gnt_q lingers one cycle after release, keeping the releasing input out of the next arbitration
  always_comb begin
    logic [PORT_W-1:0] dst;
    dst     = '0;
    bad_dst = '0;
    for (int o = 0; o < NPORTS; o++) arb_req[o] = '0;
    for (int i = 0; i < NPORTS; i++) begin
      dst        = req_dst[i*PORT_W +: PORT_W];
      bad_dst[i] = req_valid[i] & (dst >= PORT_W'(NPORTS));
      for (int o = 0; o < NPORTS; o++)
        arb_req[o][i] = req_valid[i] & ~gnt_q[i] & (dst == PORT_W'(o));
    end
  end

  for (genvar o = 0; o < NPORTS; o++) begin : g_arb
    rr_arbiter u_arb (
      .req_i     (arb_req[o]),
      .ptr_i     (ptr_q[o]),
      .valid_o   (arb_valid[o]),
      .gnt_o     (arb_gnt[o]),
      .gnt_idx_o (arb_idx[o]),
      .ptr_nxt_o (arb_ptr[o])
    );
  end

  always_comb begin
    owns      = '0;
    credit_ok = '0;
    out_acc   = '0;
    out_rel   = '0;
    for (int o = 0; o < NPORTS; o++)
      for (int i = 0; i < NPORTS; i++)
        if (state_q[o] == OUT_LOCKED && sel_q[o] == PORT_W'(i)) begin
          owns[i]      = 1'b1;
          credit_ok[i] = has_cred[o];
        end
    flit_ok = owns & credit_ok;
    accept  = in_xfer & flit_ok;
    for (int o = 0; o < NPORTS; o++)
      for (int i = 0; i < NPORTS; i++)
        if (state_q[o] == OUT_LOCKED && sel_q[o] == PORT_W'(i)) begin
          out_acc[o] = accept[i];
          out_rel[o] = accept[i] & in_tail[i];
        end
  end

`ifdef SWA_CREDIT_EN
  logic [CRED_W-1:0] cred_q [NPORTS];
  logic [CRED_W-1:0] cred_d [NPORTS];

  always_comb begin
    for (int o = 0; o < NPORTS; o++) has_cred[o] = (cred_q[o] != '0);
  end

  always_comb begin
    cred_ovf = '0;
    for (int o = 0; o < NPORTS; o++) begin
      cred_d[o] = cred_q[o];
      if (out_acc[o] && !credit_ret[o]) begin
        cred_d[o] = cred_q[o] - 1'b1;
      end else if (credit_ret[o] && !out_acc[o]) begin
        if (cred_q[o] == CRED_W'(CREDITS)) cred_ovf[o] = 1'b1;
        else                               cred_d[o]   = cred_q[o] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int o = 0; o < NPORTS; o++) begin
      if (reset) cred_q[o] <= CRED_W'(CREDITS);
      else       cred_q[o] <= cred_d[o];
    end
  end
`else
  logic unused_credit_ret;
  assign unused_credit_ret = ^credit_ret;
  assign has_cred          = '1;
  assign cred_ovf          = '0;
`endif

  always_comb begin
    granted = '0;
    for (int o = 0; o < NPORTS; o++) begin
      state_d[o] = state_q[o];
      sel_d[o]   = sel_q[o];
      ptr_d[o]   = ptr_q[o];
      case (state_q[o])
        OUT_IDLE: begin
          if (arb_valid[o]) begin
            state_d[o] = OUT_LOCKED;
            sel_d[o]   = arb_idx[o];
            ptr_d[o]   = arb_ptr[o];
            granted    = granted | arb_gnt[o];
          end
        end
        OUT_LOCKED: begin
          if (out_rel[o]) state_d[o] = OUT_IDLE;
        end
        default: state_d[o] = OUT_IDLE;
      endcase
    end
    gnt_d = owns | granted;
    err_d = err_q | (|bad_dst) | (|(in_xfer & ~flit_ok)) | (|cred_ovf);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int o = 0; o < NPORTS; o++) begin
        state_q[o] <= OUT_IDLE;
        sel_q[o]   <= '0;
        ptr_q[o]   <= '0;
      end
      gnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      for (int o = 0; o < NPORTS; o++) begin
        state_q[o] <= state_d[o];
        sel_q[o]   <= sel_d[o];
        ptr_q[o]   <= ptr_d[o];
      end
      gnt_q <= gnt_d;
      err_q <= err_d;
    end
  end

  always_comb begin
    xbar_sel = '0;
    out_busy = '0;
    for (int o = 0; o < NPORTS; o++) begin
      xbar_sel[o*PORT_W +: PORT_W] = sel_q[o];
      out_busy[o]                  = (state_q[o] == OUT_LOCKED);
    end
  end

  assign gnt = gnt_q;
  assign err = err_q;

endmodule

// File: tb/tb_noc_switch_allocator.sv
// Bench for noc_switch_allocator: directed scenarios plus random traffic against an
// owner-table reference model (honours SWA_CREDIT_EN).
module tb_noc_switch_allocator;

  localparam int N    = 5;
  localparam int W    = 3;
  localparam int CRED = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_dst;
  logic [N-1:0]   in_xfer;
  logic [N-1:0]   in_tail;
  logic [N-1:0]   credit_ret;
  logic [N-1:0]   gnt;
  logic [N-1:0]   flit_ok;
  logic [N*W-1:0] xbar_sel;
  logic [N-1:0]   out_busy;
  logic           err;

  always #5 clk = ~clk;

  noc_switch_allocator dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_dst    (req_dst),
    .in_xfer    (in_xfer),
    .in_tail    (in_tail),
    .credit_ret (credit_ret),
    .gnt        (gnt),
    .flit_ok    (flit_ok),
    .xbar_sel   (xbar_sel),
    .out_busy   (out_busy),
    .err        (err)
  );

  // model: owner of each output (-1 = free), last selected input, RR pointer, credits
  int       m_owner [N];
  int       m_sel   [N];
  int       m_ptr   [N];
  int       m_cred  [N];
  bit [N-1:0] m_gnt;
  bit       m_err;
  int       n_cmp = 0;
  int       n_bad = 0;

  function automatic void model_reset();
    for (int o = 0; o < N; o++) begin
      m_owner[o] = -1; m_sel[o] = 0; m_ptr[o] = 0; m_cred[o] = CRED;
    end
    m_gnt = '0;
    m_err = 1'b0;
  endfunction

  function automatic int dst_of(int i);
    return int'(req_dst[i*W +: W]);
  endfunction

  function automatic int owned_out(int i);
    for (int o = 0; o < N; o++) if (m_owner[o] == i) return o;
    return -1;
  endfunction

  function automatic bit m_fok(int i);
    int o;
    o = owned_out(i);
    if (o < 0) return 1'b0;
`ifdef SWA_CREDIT_EN
    return m_cred[o] > 0;
`else
    return 1'b1;
`endif
  endfunction

  function automatic logic [N-1:0] exp_busy();
    logic [N-1:0] b;
    for (int o = 0; o < N; o++) b[o] = (m_owner[o] >= 0);
    return b;
  endfunction

  function automatic logic [N-1:0] exp_fok();
    logic [N-1:0] f;
    for (int i = 0; i < N; i++) f[i] = m_fok(i);
    return f;
  endfunction

  function automatic void model_step();
    bit [N-1:0] acc;
    bit [N-1:0] ng;
    int nown [N];
    int k, base, cand;
    bit found, used;
    if (reset) begin
      model_reset();
      return;
    end
    acc = '0;
    ng  = '0;
    for (int j = 0; j < N; j++) begin
      acc[j] = in_xfer[j] && m_fok(j);
      if (in_xfer[j] && !m_fok(j)) m_err = 1'b1;
      if (req_valid[j] && dst_of(j) >= N) m_err = 1'b1;
      ng[j] = (owned_out(j) >= 0);
    end
    for (int o = 0; o < N; o++) begin
      nown[o] = m_owner[o];
      k = m_owner[o];
      used = (k >= 0) && acc[k];
      if (k >= 0) begin
        if (used && in_tail[k]) nown[o] = -1;
      end else begin
        found = 1'b0;
        base  = m_ptr[o];
        for (int c = 0; c < N; c++) begin
          cand = (base + c) % N;
          if (!found && req_valid[cand] && dst_of(cand) == o && !m_gnt[cand]) begin
            found = 1'b1;
            nown[o] = cand;
            m_sel[o] = cand;
            m_ptr[o] = (cand + 1) % N;
            ng[cand] = 1'b1;
          end
        end
      end
`ifdef SWA_CREDIT_EN
      if (used && !credit_ret[o]) m_cred[o] = m_cred[o] - 1;
      else if (credit_ret[o] && !used) begin
        if (m_cred[o] == CRED) m_err = 1'b1;
        else m_cred[o] = m_cred[o] + 1;
      end
`endif
    end
    m_owner = nown;
    m_gnt   = ng;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic set_idle();
    req_valid = '0; req_dst = '0; in_xfer = '0; in_tail = '0; credit_ret = '0;
  endtask

  task automatic set_req(int i, int d);
    req_valid[i] = 1'b1;
    req_dst[i*W +: W] = W'(d);
  endtask

  task automatic do_reset();
    set_idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (gnt !== 5'b0) begin $display("FAIL reset_gnt: got %b want %b", gnt, 5'b0); n_bad++; end
    n_cmp++; if (out_busy !== 5'b0) begin $display("FAIL reset_busy: got %b want %b", out_busy, 5'b0); n_bad++; end
    n_cmp++; if (xbar_sel !== 15'b0) begin $display("FAIL reset_xbar: got %h want 0", xbar_sel); n_bad++; end
    n_cmp++; if (err !== 1'b0) begin $display("FAIL reset_err: got %b want 0", err); n_bad++; end
    n_cmp++; if (flit_ok !== 5'b0) begin $display("FAIL reset_flit_ok: got %b want 0", flit_ok); n_bad++; end
  endtask

  task automatic test_single_grant();
    do_reset();
    set_req(1, 3);
    tick();
    n_cmp++; if (gnt !== 5'b00010) begin $display("FAIL single_gnt: got %b want 00010", gnt); n_bad++; end
    n_cmp++; if (out_busy !== 5'b01000) begin $display("FAIL single_busy: got %b want 01000", out_busy); n_bad++; end
    n_cmp++; if (xbar_sel[9 +: 3] !== 3'd1) begin $display("FAIL single_xbar: got %0d want 1", xbar_sel[9 +: 3]); n_bad++; end
    n_cmp++; if (flit_ok !== 5'b00010) begin $display("FAIL single_flit_ok: got %b want 00010", flit_ok); n_bad++; end
    req_valid = '0; in_xfer[1] = 1'b1; in_tail[1] = 1'b1;
    tick();
    set_idle();
    n_cmp++; if (out_busy !== 5'b0) begin $display("FAIL single_release: busy %b want 0", out_busy); n_bad++; end
    n_cmp++; if (gnt !== 5'b00010) begin $display("FAIL single_gnt_linger: got %b want 00010", gnt); n_bad++; end
    n_cmp++; if (flit_ok !== 5'b0) begin $display("FAIL single_flit_ok_off: got %b want 0", flit_ok); n_bad++; end
    tick();
    n_cmp++; if (gnt !== 5'b0) begin $display("FAIL single_gnt_drop: got %b want 0", gnt); n_bad++; end
    // pointer of output 3 now sits at 2, so input 2 beats input 1
    set_req(1, 3); set_req(2, 3);
    tick();
    n_cmp++; if (gnt !== 5'b00100) begin $display("FAIL single_ptr_gnt: got %b want 00100", gnt); n_bad++; end
    n_cmp++; if (xbar_sel[9 +: 3] !== 3'd2) begin $display("FAIL single_ptr_xbar: got %0d want 2", xbar_sel[9 +: 3]); n_bad++; end
  endtask

  task automatic test_contention();
    int order[$];
    int gaps[$];
    int exp_ord[4] = '{0, 2, 4, 0};
    int idle, got, k;
    bit prev_busy, seen;
    do_reset();
    set_req(0, 4); set_req(2, 4); set_req(4, 4);
    idle = 0; prev_busy = 1'b0; seen = 1'b0;
    for (int cyc = 0; cyc < 40 && order.size() < 4; cyc++) begin
      in_xfer = '0; in_tail = '0;
      if (out_busy[4]) begin
        k = int'(xbar_sel[12 +: 3]);
        if (!prev_busy) begin
          order.push_back(k);
          if (seen) gaps.push_back(idle);
          seen = 1'b1; idle = 0;
        end
        in_xfer[k] = 1'b1; in_tail[k] = 1'b1;
      end else if (seen) idle++;
      prev_busy = out_busy[4];
      tick();
    end
    set_idle();
    for (int j = 0; j < 4; j++) begin
      got = (j < order.size()) ? order[j] : -1;
      n_cmp++;
      if (got != exp_ord[j]) begin $display("FAIL contention_order[%0d]: got %0d want %0d", j, got, exp_ord[j]); n_bad++; end
    end
    for (int j = 0; j < 3; j++) begin
      got = (j < gaps.size()) ? gaps[j] : -1;
      n_cmp++;
      if (got != 1) begin $display("FAIL contention_bubble[%0d]: got %0d idle cycles want 1", j, got); n_bad++; end
    end
  endtask

  task automatic test_lock_hold();
    do_reset();
    set_req(0, 2); set_req(1, 2);
    tick();
    n_cmp++; if (gnt !== 5'b00001) begin $display("FAIL hold_first: got %b want 00001", gnt); n_bad++; end
    for (int f = 0; f < 4; f++) begin
      in_xfer[0] = 1'b1;
      in_tail[0] = (f == 3);
      if (f == 3) req_valid[0] = 1'b0;
      tick();
      n_cmp++; if (gnt[1] !== 1'b0) begin $display("FAIL hold_gnt1[%0d]: got %b want 0", f, gnt[1]); n_bad++; end
    end
    in_xfer = '0; in_tail = '0;
    n_cmp++; if (out_busy[2] !== 1'b0) begin $display("FAIL hold_release: busy %b want 0", out_busy[2]); n_bad++; end
    tick();
    n_cmp++; if (gnt[1] !== 1'b1) begin $display("FAIL hold_next: gnt1 %b want 1", gnt[1]); n_bad++; end
    n_cmp++; if (xbar_sel[6 +: 3] !== 3'd1) begin $display("FAIL hold_next_xbar: got %0d want 1", xbar_sel[6 +: 3]); n_bad++; end
    set_idle();
  endtask

  task automatic test_credits();
    do_reset();
    set_req(0, 1);
    tick();
    req_valid = '0;
`ifdef SWA_CREDIT_EN
    for (int f = 0; f < 4; f++) begin
      n_cmp++; if (flit_ok[0] !== 1'b1) begin $display("FAIL credit_ok[%0d]: got %b want 1", f, flit_ok[0]); n_bad++; end
      in_xfer[0] = 1'b1;
      tick();
    end
    in_xfer = '0;
    n_cmp++; if (flit_ok[0] !== 1'b0) begin $display("FAIL credit_empty: flit_ok %b want 0", flit_ok[0]); n_bad++; end
    n_cmp++; if (gnt[0] !== 1'b1) begin $display("FAIL credit_still_gnt: gnt %b want 1", gnt[0]); n_bad++; end
    credit_ret[1] = 1'b1;
    tick();
    credit_ret = '0;
    n_cmp++; if (flit_ok[0] !== 1'b1) begin $display("FAIL credit_return: flit_ok %b want 1", flit_ok[0]); n_bad++; end
    in_xfer[0] = 1'b1; credit_ret[1] = 1'b1;
    tick();
    n_cmp++; if (flit_ok[0] !== 1'b1) begin $display("FAIL credit_both: flit_ok %b want 1", flit_ok[0]); n_bad++; end
    credit_ret = '0; in_tail[0] = 1'b1;
    tick();
    in_xfer = '0; in_tail = '0;
    n_cmp++; if (out_busy[1] !== 1'b0) begin $display("FAIL credit_tail: busy %b want 0", out_busy[1]); n_bad++; end
    credit_ret[1] = 1'b1;
    repeat (4) tick();
    n_cmp++; if (err !== 1'b0) begin $display("FAIL credit_refill_err: got %b want 0", err); n_bad++; end
    tick();
    credit_ret = '0;
    n_cmp++; if (err !== 1'b1) begin $display("FAIL credit_overflow_err: got %b want 1", err); n_bad++; end
`else
    credit_ret = '1;
    for (int f = 0; f < 6; f++) begin
      n_cmp++; if (flit_ok[0] !== 1'b1) begin $display("FAIL nocredit_ok[%0d]: got %b want 1", f, flit_ok[0]); n_bad++; end
      in_xfer[0] = 1'b1;
      in_tail[0] = (f == 5);
      tick();
    end
    set_idle();
    n_cmp++; if (err !== 1'b0) begin $display("FAIL nocredit_err: got %b want 0", err); n_bad++; end
    n_cmp++; if (out_busy !== 5'b0) begin $display("FAIL nocredit_release: busy %b want 0", out_busy); n_bad++; end
`endif
    set_idle();
  endtask

  task automatic test_random();
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int i = 0; i < N; i++) begin
        req_valid[i] = ($urandom_range(0, 1) == 1);
        req_dst[i*W +: W] = W'($urandom_range(0, N-1));
        in_xfer[i] = m_fok(i) && ($urandom_range(0, 9) < 7);
        in_tail[i] = ($urandom_range(0, 2) == 0);
      end
      for (int o = 0; o < N; o++) begin
        credit_ret[o] = ($urandom_range(0, 3) == 0);
`ifdef SWA_CREDIT_EN
        if (m_cred[o] >= CRED) credit_ret[o] = 1'b0;
`endif
      end
      tick();
      n_cmp++; if (gnt !== m_gnt) begin $display("FAIL rand_gnt@%0d: got %b want %b", cyc, gnt, m_gnt); n_bad++; end
      n_cmp++; if (out_busy !== exp_busy()) begin $display("FAIL rand_busy@%0d: got %b want %b", cyc, out_busy, exp_busy()); n_bad++; end
      n_cmp++; if (flit_ok !== exp_fok()) begin $display("FAIL rand_flit_ok@%0d: got %b want %b", cyc, flit_ok, exp_fok()); n_bad++; end
      n_cmp++; if (err !== m_err) begin $display("FAIL rand_err@%0d: got %b want %b", cyc, err, m_err); n_bad++; end
      for (int o = 0; o < N; o++) begin
        if (m_owner[o] >= 0) begin
          n_cmp++;
          if (int'(xbar_sel[o*W +: W]) != m_sel[o]) begin
            $display("FAIL rand_xbar@%0d out %0d: got %0d want %0d", cyc, o, xbar_sel[o*W +: W], m_sel[o]); n_bad++;
          end
        end
      end
    end
    set_idle();
  endtask

  task automatic test_errors();
    do_reset();
    set_req(0, 5);
    tick();
    set_idle();
    n_cmp++; if (gnt !== 5'b0) begin $display("FAIL err_dst_gnt: got %b want 0", gnt); n_bad++; end
    n_cmp++; if (out_busy !== 5'b0) begin $display("FAIL err_dst_busy: got %b want 0", out_busy); n_bad++; end
    n_cmp++; if (err !== 1'b1) begin $display("FAIL err_dst_flag: got %b want 1", err); n_bad++; end
    do_reset();
    in_xfer[3] = 1'b1;
    tick();
    set_idle();
    n_cmp++; if (err !== 1'b1) begin $display("FAIL err_xfer_flag: got %b want 1", err); n_bad++; end
    n_cmp++; if (gnt !== 5'b0 || out_busy !== 5'b0) begin $display("FAIL err_xfer_state: gnt %b busy %b want 0 0", gnt, out_busy); n_bad++; end
  endtask

  task automatic test_reset_midpacket();
    do_reset();
    set_req(0, 1); set_req(1, 2); set_req(2, 3);
    tick();
    set_idle();
    n_cmp++; if (out_busy !== 5'b01110) begin $display("FAIL mid_locked: busy %b want 01110", out_busy); n_bad++; end
    in_xfer[0] = 1'b1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    set_idle();
    n_cmp++; if (gnt !== 5'b0) begin $display("FAIL mid_gnt: got %b want 0", gnt); n_bad++; end
    n_cmp++; if (out_busy !== 5'b0) begin $display("FAIL mid_busy: got %b want 0", out_busy); n_bad++; end
    // output 1 pointer back at 0: input 0 must beat input 4
    set_req(0, 1); set_req(4, 1);
    tick();
    set_idle();
    n_cmp++; if (gnt !== 5'b00001) begin $display("FAIL mid_ptr_gnt: got %b want 00001", gnt); n_bad++; end
    n_cmp++; if (xbar_sel[3 +: 3] !== 3'd0) begin $display("FAIL mid_ptr_xbar: got %0d want 0", xbar_sel[3 +: 3]); n_bad++; end
  endtask

  initial begin
    reset = 1'b1;
    set_idle();
    model_reset();
    test_reset();
    test_single_grant();
    test_contention();
    test_lock_hold();
    test_credits();
    test_random();
    test_errors();
    test_reset_midpacket();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: run still active at %0t, limit 400000", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
